// File: rtl/mips_sim_pkg.sv
// Shared types and MIPS encodings for the simulation harness.
package mips_sim_pkg;

   typedef enum logic [1:0] {
      RESET   = 2'd0,
      RUN     = 2'd1,
      HALTED  = 2'd2,
      TIMEOUT = 2'd3
   } run_state_t;

   localparam logic [31:0] MIPS_BREAK_WORD  = 32'h0000000D;
   localparam logic [31:0] MIPS_SELF_BRANCH = 32'h1000FFFF;

endpackage

// File: rtl/run_trace_buf.sv
// Ring buffer of recently retired PCs; read index 0 is the newest entry.
module run_trace_buf #(
   parameter int unsigned XLEN        = 32,
   parameter int unsigned TRACE_DEPTH = 8
) (
   input  logic                           clk,
   input  logic                           rst_n,
   input  logic                           wr_en,
   input  logic [XLEN-1:0]                wr_data,
   input  logic [$clog2(TRACE_DEPTH)-1:0] rd_idx,
   output logic [XLEN-1:0]                rd_data,
   output logic [$clog2(TRACE_DEPTH):0]   level
);

   localparam int unsigned IDX_W = $clog2(TRACE_DEPTH);
   localparam int unsigned LVL_W = IDX_W + 1;

   logic [XLEN-1:0]  mem_q [TRACE_DEPTH];
   logic [IDX_W-1:0] wptr_q, wptr_d;
   logic [IDX_W-1:0] rd_ptr_c;
   logic [LVL_W-1:0] level_q, level_d;

   // Pointer wraps naturally because the depth is a power of two.
   always_comb begin
      wptr_d  = wptr_q;
      level_d = level_q;
      if (wr_en) begin
         wptr_d = wptr_q + IDX_W'(1);
         if (level_q != LVL_W'(TRACE_DEPTH)) begin
            level_d = level_q + LVL_W'(1);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         wptr_q  <= '0;
         level_q <= '0;
      end else begin
         wptr_q  <= wptr_d;
         level_q <= level_d;
      end
   end

   // Storage is not reset; entries beyond level are masked on read.
   always_ff @(posedge clk) begin
      if (wr_en) begin
         mem_q[wptr_q] <= wr_data;
      end
   end

   always_comb begin
      rd_ptr_c = wptr_q - IDX_W'(1) - rd_idx;
      rd_data  = ({1'b0, rd_idx} < level_q) ? mem_q[rd_ptr_c] : '0;
   end

   assign level = level_q;

endmodule

// File: rtl/mips_run_ctrl.sv
// Run controller for the single-cycle MIPS harness: core reset sequencing, run counters,
// termination detection. Define MIPS_RUN_TRACE_EN to build the retired-PC trace buffer.
module mips_run_ctrl
   import mips_sim_pkg::*;
#(
   parameter int unsigned XLEN        = 32,
   parameter int unsigned RST_CYCLES  = 4,
   parameter int unsigned MAX_CYCLES  = 1024,
   parameter logic [31:0] HALT_WORD   = MIPS_BREAK_WORD,
   parameter int unsigned LOOP_N      = 3,
   parameter int unsigned TRACE_DEPTH = 8,
   parameter int unsigned CNT_W       = 32
) (
   input  logic                           clk,
   input  logic                           rst_n,
   input  logic                           instr_valid,
   input  logic [XLEN-1:0]                pc,
   input  logic [31:0]                    instr,
   input  logic                           ext_halt,
   input  logic [$clog2(TRACE_DEPTH)-1:0] trace_idx,
   output logic                           cpu_rst,
   output logic                           core_en,
   output logic [1:0]                     state,
   output logic                           halted,
   output logic                           timeout,
   output logic [CNT_W-1:0]               cycle_count,
   output logic [CNT_W-1:0]               retired_count,
   output logic [XLEN-1:0]                trace_pc,
   output logic [$clog2(TRACE_DEPTH):0]   trace_level
);

   localparam int unsigned RCNT_W = $clog2(RST_CYCLES + 1);
   localparam int unsigned RUN_W  = $clog2(LOOP_N);

   run_state_t        state_q, state_d;
   logic [RCNT_W-1:0] rcnt_q, rcnt_d;
   logic [CNT_W-1:0]  cyc_q, cyc_d;
   logic [CNT_W-1:0]  ret_q, ret_d;
   logic [XLEN-1:0]   prev_pc_q, prev_pc_d;
   logic              prev_vld_q, prev_vld_d;
   logic [RUN_W-1:0]  run_q, run_d, run_nx_c;
   logic              cpu_rst_q, cpu_rst_d;
   logic              core_en_q, core_en_d;
   logic              halted_q, halted_d;
   logic              timeout_q, timeout_d;
   logic              in_run_c, retire_c, same_pc_c, loop_hit_c, halt_c, tmo_c;

   // Termination causes; a halt cause takes priority over the timeout.
   always_comb begin
      in_run_c   = (state_q == RUN);
      retire_c   = in_run_c && instr_valid;
      same_pc_c  = prev_vld_q && (pc == prev_pc_q);
      run_nx_c   = (run_q == RUN_W'(LOOP_N - 1)) ? run_q : run_q + RUN_W'(1);
      loop_hit_c = retire_c && same_pc_c && (run_nx_c == RUN_W'(LOOP_N - 1));
      halt_c     = in_run_c && (ext_halt || (instr_valid && (instr == HALT_WORD)) || loop_hit_c);
      tmo_c      = in_run_c && (cyc_q == CNT_W'(MAX_CYCLES - 1));
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= RESET;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         RESET:   if (rcnt_q == '0) state_d = RUN;
         RUN:     if (halt_c) state_d = HALTED;
                  else if (tmo_c) state_d = TIMEOUT;
         default: state_d = state_q;
      endcase
   end

   always_comb begin
      cpu_rst_d = (state_d == RESET);
      core_en_d = (state_d == RUN);
      halted_d  = (state_d == HALTED);
      timeout_d = (state_d == TIMEOUT);
   end

   // cycle_count stops on the terminating cycle, so it reports that cycle's index.
   always_comb begin
      rcnt_d     = rcnt_q;
      cyc_d      = cyc_q;
      ret_d      = ret_q;
      prev_pc_d  = prev_pc_q;
      prev_vld_d = prev_vld_q;
      run_d      = run_q;
      if ((state_q == RESET) && (rcnt_q != '0)) begin
         rcnt_d = rcnt_q - RCNT_W'(1);
      end
      if (in_run_c && !halt_c && !tmo_c && (cyc_q != '1)) begin
         cyc_d = cyc_q + CNT_W'(1);
      end
      if (retire_c) begin
         if (ret_q != '1) begin
            ret_d = ret_q + CNT_W'(1);
         end
         prev_pc_d  = pc;
         prev_vld_d = 1'b1;
         run_d      = same_pc_c ? run_nx_c : '0;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         rcnt_q     <= RCNT_W'(RST_CYCLES);
         cyc_q      <= '0;
         ret_q      <= '0;
         prev_pc_q  <= '0;
         prev_vld_q <= 1'b0;
         run_q      <= '0;
         cpu_rst_q  <= 1'b1;
         core_en_q  <= 1'b0;
         halted_q   <= 1'b0;
         timeout_q  <= 1'b0;
      end else begin
         rcnt_q     <= rcnt_d;
         cyc_q      <= cyc_d;
         ret_q      <= ret_d;
         prev_pc_q  <= prev_pc_d;
         prev_vld_q <= prev_vld_d;
         run_q      <= run_d;
         cpu_rst_q  <= cpu_rst_d;
         core_en_q  <= core_en_d;
         halted_q   <= halted_d;
         timeout_q  <= timeout_d;
      end
   end

   assign state         = state_q;
   assign cpu_rst       = cpu_rst_q;
   assign core_en       = core_en_q;
   assign halted        = halted_q;
   assign timeout       = timeout_q;
   assign cycle_count   = cyc_q;
   assign retired_count = ret_q;

`ifdef MIPS_RUN_TRACE_EN
   run_trace_buf #(
      .XLEN        (XLEN),
      .TRACE_DEPTH (TRACE_DEPTH)
   ) u_trace (
      .clk     (clk),
      .rst_n   (rst_n),
      .wr_en   (retire_c),
      .wr_data (pc),
      .rd_idx  (trace_idx),
      .rd_data (trace_pc),
      .level   (trace_level)
   );
`else
   logic unused_trace_c;
   assign unused_trace_c = ^trace_idx;
   assign trace_pc       = '0;
   assign trace_level    = '0;
`endif

endmodule

// File: tb/tb_mips_run_ctrl.sv
// Self-checking bench for mips_run_ctrl: directed scenarios plus random runs against
// a history-based reference model (retired-PC list, edge counts since reset release).
module tb_mips_run_ctrl;
   import mips_sim_pkg::*;

   localparam int unsigned XLEN        = 32;
   localparam int unsigned RST_CYCLES  = 4;
   localparam int unsigned MAX_CYCLES  = 16;
   localparam int unsigned LOOP_N      = 3;
   localparam int unsigned TRACE_DEPTH = 8;
   localparam int unsigned CNT_W       = 32;
   localparam int unsigned IDX_W       = $clog2(TRACE_DEPTH);
   localparam logic [31:0] HALT_WORD   = MIPS_BREAK_WORD;
   localparam logic [31:0] NOP         = 32'h00000000;

   logic                clk = 1'b0;
   logic                rst_n = 1'b0;
   logic                instr_valid = 1'b0;
   logic [XLEN-1:0]     pc = '0;
   logic [31:0]         instr = '0;
   logic                ext_halt = 1'b0;
   logic [IDX_W-1:0]    trace_idx = '0;
   logic                cpu_rst, core_en, halted, timeout;
   logic [1:0]          state;
   logic [CNT_W-1:0]    cycle_count, retired_count;
   logic [XLEN-1:0]     trace_pc;
   logic [IDX_W:0]      trace_level;

   int n_checks = 0;
   int n_errors = 0;

   // Reference model: state code, edges since release, counts and the PCs retired this run.
   int          m_state = 0;
   int          m_rel = 0;
   int unsigned m_cyc = 0;
   int unsigned m_ret = 0;
   bit          m_halted = 1'b0;
   bit          m_timeout = 1'b0;
   logic [31:0] hist[$];

   mips_run_ctrl #(
      .XLEN(XLEN), .RST_CYCLES(RST_CYCLES), .MAX_CYCLES(MAX_CYCLES), .HALT_WORD(HALT_WORD),
      .LOOP_N(LOOP_N), .TRACE_DEPTH(TRACE_DEPTH), .CNT_W(CNT_W)
   ) dut (
      .clk(clk), .rst_n(rst_n), .instr_valid(instr_valid), .pc(pc), .instr(instr),
      .ext_halt(ext_halt), .trace_idx(trace_idx), .cpu_rst(cpu_rst), .core_en(core_en),
      .state(state), .halted(halted), .timeout(timeout), .cycle_count(cycle_count),
      .retired_count(retired_count), .trace_pc(trace_pc), .trace_level(trace_level)
   );

   always #20 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
      end
   endtask

   // Self-loop: this PC plus the previous LOOP_N-1 retirements all identical.
   task automatic model_step();
      bit loop;
      bit halt;
      if (!rst_n) begin
         m_state = 0; m_rel = 0; m_cyc = 0; m_ret = 0;
         m_halted = 1'b0; m_timeout = 1'b0;
         hist.delete();
      end else if (m_state == 0) begin
         m_rel++;
         if (m_rel > int'(RST_CYCLES)) m_state = 1;
      end else if (m_state == 1) begin
         loop = 1'b0;
         if (instr_valid && (hist.size() >= int'(LOOP_N) - 1)) begin
            loop = 1'b1;
            for (int k = 1; k < int'(LOOP_N); k++) begin
               if (hist[hist.size() - k] != pc) loop = 1'b0;
            end
         end
         halt = ext_halt || (instr_valid && ((instr == HALT_WORD) || loop));
         if (instr_valid) begin
            m_ret++;
            hist.push_back(pc);
         end
         if (halt) begin
            m_state = 2; m_halted = 1'b1;
         end else if (m_cyc == MAX_CYCLES - 1) begin
            m_state = 3; m_timeout = 1'b1;
         end else begin
            m_cyc++;
         end
      end
   endtask

   task automatic check_all();
      int          lvl;
      logic [31:0] e;
      lvl = (hist.size() < int'(TRACE_DEPTH)) ? hist.size() : int'(TRACE_DEPTH);
      chk("state", 64'(state), 64'(m_state));
      chk("cpu_rst", 64'(cpu_rst), 64'(m_state == 0));
      chk("core_en", 64'(core_en), 64'(m_state == 1));
      chk("halted", 64'(halted), 64'(m_halted));
      chk("timeout", 64'(timeout), 64'(m_timeout));
      chk("cycle_count", 64'(cycle_count), 64'(m_cyc));
      chk("retired_count", 64'(retired_count), 64'(m_ret));
`ifdef MIPS_RUN_TRACE_EN
      chk("trace_level", 64'(trace_level), 64'(lvl));
`else
      chk("trace_level", 64'(trace_level), 64'd0);
`endif
      for (int i = 0; i < int'(TRACE_DEPTH); i++) begin
         trace_idx = IDX_W'(i);
         #1;
`ifdef MIPS_RUN_TRACE_EN
         e = (i < lvl) ? hist[hist.size() - 1 - i] : 32'h0;
`else
         e = 32'h0;
`endif
         chk("trace_pc", 64'(trace_pc), 64'(e));
      end
   endtask

   task automatic drive(input bit rn, input bit iv, input logic [31:0] p,
                        input logic [31:0] ins, input bit eh);
      rst_n = rn; instr_valid = iv; pc = p; instr = ins; ext_halt = eh;
      @(posedge clk);
      model_step();
      @(negedge clk);
      check_all();
   endtask

   task automatic do_reset(input int n);
      repeat (n) drive(1'b0, 1'b0, 32'h0, NOP, 1'b0);
      for (int k = 0; k <= int'(RST_CYCLES); k++) drive(1'b1, 1'b0, 32'h0, NOP, 1'b0);
      chk("run_after_release", 64'(state), 64'd1);
   endtask

   task automatic peek_trace(input string tag, input int idx, input logic [31:0] exp_on);
      trace_idx = IDX_W'(idx);
      #1;
`ifdef MIPS_RUN_TRACE_EN
      chk(tag, 64'(trace_pc), 64'(exp_on));
`else
      chk(tag, 64'(trace_pc), 64'd0);
`endif
   endtask

   initial begin
      // Reset for 3 cycles, release, four edges of cpu_rst then RUN.
      do_reset(3);

      // Halt word after three retirements.
      drive(1'b1, 1'b1, 32'h0, NOP, 1'b0);
      drive(1'b1, 1'b1, 32'h4, NOP, 1'b0);
      drive(1'b1, 1'b1, 32'h8, NOP, 1'b0);
      drive(1'b1, 1'b1, 32'hC, HALT_WORD, 1'b0);
      chk("brk_halted", 64'(halted), 64'd1);
      chk("brk_state", 64'(state), 64'd2);
      chk("brk_retired", 64'(retired_count), 64'd4);
      peek_trace("brk_trace0", 0, 32'hC);
      peek_trace("brk_trace3", 3, 32'h0);
      drive(1'b1, 1'b1, 32'h40, NOP, 1'b0);
      chk("brk_frozen", 64'(retired_count), 64'd4);

      // Self-loop on 0x14.
      do_reset(1);
      drive(1'b1, 1'b1, 32'h10, NOP, 1'b0);
      drive(1'b1, 1'b1, 32'h14, MIPS_SELF_BRANCH, 1'b0);
      drive(1'b1, 1'b1, 32'h14, MIPS_SELF_BRANCH, 1'b0);
      chk("loop_not_yet", 64'(state), 64'd1);
      drive(1'b1, 1'b1, 32'h14, MIPS_SELF_BRANCH, 1'b0);
      chk("loop_state", 64'(state), 64'd2);
      chk("loop_retired", 64'(retired_count), 64'd4);

      // Timeout with ever-changing PCs.
      do_reset(1);
      for (int k = 0; k < 20; k++) drive(1'b1, 1'b1, 32'h100 + 32'(4 * k), NOP, 1'b0);
      chk("tmo_timeout", 64'(timeout), 64'd1);
      chk("tmo_state", 64'(state), 64'd3);
      chk("tmo_cycles", 64'(cycle_count), 64'd15);
      chk("tmo_halted", 64'(halted), 64'd0);

      // Halt word on the last budget cycle beats the timeout.
      do_reset(1);
      for (int k = 0; k < 15; k++) drive(1'b1, 1'b1, 32'h180 + 32'(4 * k), NOP, 1'b0);
      drive(1'b1, 1'b1, 32'h200, HALT_WORD, 1'b0);
      chk("edge_halted", 64'(halted), 64'd1);
      chk("edge_timeout", 64'(timeout), 64'd0);

      // Ten retirements wrap the eight-entry trace.
      do_reset(1);
      for (int k = 0; k < 10; k++) drive(1'b1, 1'b1, 32'h300 + 32'(4 * k), NOP, 1'b0);
`ifdef MIPS_RUN_TRACE_EN
      chk("wrap_level", 64'(trace_level), 64'd8);
`else
      chk("wrap_level", 64'(trace_level), 64'd0);
`endif
      peek_trace("wrap_idx7", 7, 32'h308);

      // Mid-run reset pulse.
      do_reset(1);
      for (int k = 0; k < 5; k++) drive(1'b1, 1'b1, 32'h400 + 32'(4 * k), NOP, 1'b0);
      drive(1'b0, 1'b1, 32'h500, NOP, 1'b0);
      chk("mid_state", 64'(state), 64'd0);
      chk("mid_cycles", 64'(cycle_count), 64'd0);
      chk("mid_retired", 64'(retired_count), 64'd0);
      chk("mid_level", 64'(trace_level), 64'd0);

      // Random runs: few distinct PCs to provoke self-loops, occasional halts and resets.
      for (int r = 0; r < 30; r++) begin
         do_reset(1 + int'($urandom_range(0, 1)));
         for (int c = 0; c < 25; c++) begin
            drive(($urandom % 40) != 0,
                  ($urandom % 4) != 0,
                  32'($urandom_range(0, 3)) << 2,
                  (($urandom % 12) == 0) ? HALT_WORD : 32'($urandom),
                  ($urandom % 30) == 0);
         end
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/mips_run_ctrl.md
# mips_run_ctrl

Run controller for the single-cycle MIPS simulation harness. Sequences the core's reset, counts cycles and retired instructions, and detects program termination by halt word, PC self-loop, external request or timeout. Keeps a ring buffer of recently retired PCs. Sits between the top-level clock/reset and `SingleCycleMIPS`, and replaces fixed-time benches with run-to-completion behaviour.

## Interface
Parameters:
- `XLEN`, 32: PC width.
- `RST_CYCLES`, 4: cycles `cpu_rst` is held after `rst_n` releases; legal range is ≥1.
- `MAX_CYCLES`, 1024: RUN-state cycle budget before timeout.
- `HALT_WORD`, 32'h0000000D: instruction encoding (`break`) that terminates the run.
- `LOOP_N`, 3: number of consecutive retirements at the same PC that count as a self-loop halt; legal range is ≥2.
- `TRACE_DEPTH`, 8: ring-buffer entries; must be a power of two.
- `CNT_W`, 32: counter width.

Ports:
- `clk`  in  1  clock.
- `rst_n`  in  1  reset, synchronous, active-low.
- `instr_valid`  in  1  one instruction retires this cycle.
- `pc`  in  XLEN  PC of the retiring instruction.
- `instr`  in  32  encoding of the retiring instruction.
- `ext_halt`  in  1  bench-requested stop.
- `trace_idx`  in  $clog2(TRACE_DEPTH)  selects an entry; 0 is the most recent.
- `cpu_rst`  out  1  active-high reset to the core.
- `core_en`  out  1  core enable; 0 freezes PC/register-file writes.
- `state`  out  2  current FSM state.
- `halted`  out  1  sticky; set on halt-word, self-loop or `ext_halt` termination.
- `timeout`  out  1  sticky; set on budget exhaustion.
- `cycle_count`  out  CNT_W  counts RUN cycles.
- `retired_count`  out  CNT_W  counts retired instructions.
- `trace_pc`  out  XLEN  PC at `trace_idx`.
- `trace_level`  out  $clog2(TRACE_DEPTH)+1  number of valid entries.

## Operation
- FSM states: RESET=0, RUN=1, HALTED=2, TIMEOUT=3.
- RESET:
  - `cpu_rst`=1, `core_en`=0.
  - A countdown loads `RST_CYCLES`.
  - Transitions to RUN on the cycle the countdown reaches 0.
- RUN:
  - `cpu_rst`=0, `core_en`=1.
  - `cycle_count` increments every cycle.
  - `retired_count` increments on `instr_valid`.
  - Only `instr_valid` cycles are inspected for halt conditions and written to the trace.
- Halt conditions, evaluated in RUN only, all going to HALTED:
  - `instr_valid` && `instr`==`HALT_WORD`.
  - `instr_valid` && `pc` equal to the previous retired PC, with the run-length counter reaching `LOOP_N`-1.
  - `ext_halt`=1.
- Self-loop run length:
  - Resets to 0 on any differing PC.
  - Saturates at `LOOP_N`-1.
- Timeout: `cycle_count`==`MAX_CYCLES`-1 in RUN with no halt condition → TIMEOUT.
- If a halt condition and the timeout coincide, HALTED wins and `timeout` stays 0.
- HALTED and TIMEOUT are terminal until `rst_n`=0.
  - `core_en`=0.
  - Counters freeze.
  - Trace freezes; reads remain valid.
- Counters saturate at all-ones and never wrap.
- Trace buffer:
  - Written on each RUN `instr_valid`, including the halting instruction.
  - Write pointer wraps modulo `TRACE_DEPTH`.
  - `trace_level` saturates at `TRACE_DEPTH`.
  - Reading `trace_idx` ≥ `trace_level` returns 0.

## Timing
- Reset is sampled on the `clk` rising edge. While `rst_n`=0, outputs are:
  - `state`=RESET, `cpu_rst`=1, `core_en`=0.
  - `halted`=0, `timeout`=0.
  - `cycle_count`=0, `retired_count`=0.
  - `trace_level`=0, `trace_pc`=0.
- `cpu_rst` stays high for exactly `RST_CYCLES` edges after the first edge sampling `rst_n`=1.
- Termination latency is 1 cycle. After the edge sampling the cause:
  - `state`, `halted`/`timeout` and `core_en`=0 are all registered together.
  - The halting instruction itself is counted and traced.
- `trace_pc` is combinational from `trace_idx` and registered buffer contents. A write on edge N is visible at idx 0 after edge N.
- `rst_n`=0 mid-run: the next edge returns to RESET, clears counters and flags, and empties the trace. Buffer contents are don't-care but are not observable.

## Configuration
- `MIPS_RUN_TRACE_EN`, when defined: the ring buffer and read port are implemented as above.
- When undefined:
  - No trace storage is built.
  - `trace_pc`=0 and `trace_level`=0 constantly.
  - All other behaviour is unchanged.

## Structure
- Package `mips_sim_pkg` holds:
  - The `run_state_t` enum (RESET/RUN/HALTED/TIMEOUT).
  - `MIPS_BREAK_WORD`=32'h0000000D.
  - `MIPS_SELF_BRANCH`=32'h1000FFFF.
- Sub-module `run_trace_buf` is the ring buffer, parametrised on `XLEN` and `TRACE_DEPTH`. Its interface:
  - Write: `wr_en`, `wr_data`.
  - Read: `rd_idx` → `rd_data`, plus `level`.
  - It is instantiated only under `MIPS_RUN_TRACE_EN`.

## Test plan
- Reset held 3 cycles, then released with `RST_CYCLES`=4 → `cpu_rst`=1 for 4 edges after release; `state`=RUN and `core_en`=1 on edge 5.
- Retire PCs 0x0, 0x4, 0x8, then `instr`=0x0000000D at 0xC → `halted`=1 and `state`=2 one cycle later; `retired_count`=4; `trace_pc`(0)=0xC, (3)=0x0; `trace_level`=4.
- Retire 0x10, then 0x14 three times with 0x1000FFFF (`LOOP_N`=3) → HALTED after the third 0x14; `retired_count`=4.
- `MAX_CYCLES`=16 with retirements at always-different PCs → `timeout`=1, `state`=3, `cycle_count`=15, `halted`=0.
- Halt word retired on cycle `MAX_CYCLES`-1 → `halted`=1 and `timeout`=0. Separately, retire 10 PCs with `TRACE_DEPTH`=8 → `trace_level`=8 and idx 7 holds the 3rd PC.
- `rst_n`=0 for 1 cycle mid-RUN → next cycle `state`=RESET, counters 0, `trace_level`=0. Without `MIPS_RUN_TRACE_EN`, `trace_pc` is always 0.
